branch_resolve_ctrl: RTL and testbench

ID-stage branch resolution and branch-hazard stall controller for the 5-stage MIPS pipeline.
- Consumes the 2-bit ForwardA/ForwardB codes from the branch forwarding unit.
- Selects the forwarded operands, compares them for beq/bne, and drives PCSrc and the IF/ID flush.
- Runs a stall FSM when a branch operand is not yet available for forwarding.
- Keeps saturating performance counters.

---
 rtl/branch_resolve_ctrl_pkg.sv | 16 +
 rtl/branch_operand_mux.sv | 23 ++
 rtl/branch_resolve_ctrl.sv | 157 +++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the ID-stage branch resolution controller:
// forwarding-select codes, FSM state encoding and the default data width.
package branch_resolve_ctrl_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/branch_operand_mux.sv
// 3:1 operand select for one branch comparator input; code 11 falls back to
// the register-file value.
module branch_operand_mux
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        case (sel)
            FWD_EXMEM: operand = exmem_data;
            FWD_MEMWB: operand = memwb_data;
            default:   operand = reg_data;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage beq/bne resolution with branch-hazard stall FSM and saturating
// performance counters for the 5-stage pipeline.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_beq,
    input  logic              id_bne,
    input  logic              id_jump,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [1:0]        forward_a,
    input  logic [1:0]        forward_b,
    input  logic [DATA_W-1:0] exmem_alu_result,
    input  logic [DATA_W-1:0] memwb_write_data,
    input  logic              idex_reg_write,
    input  logic              idex_mem_read,
    input  logic [4:0]        idex_rd,
    input  logic              exmem_mem_read,
    input  logic [4:0]        exmem_rd,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              pc_src,
    output logic              ifid_flush,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  taken_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic uses(input logic [4:0] r, input logic [4:0] rs,
                                  input logic [4:0] rt);
        return (r != 5'd0) && ((r == rs) || (r == rt));
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        remain_q, remain_d;
    logic [CNT_W-1:0]  branch_cnt_q, taken_cnt_q, stall_cnt_q;
    logic [DATA_W-1:0] op_a, op_b;
    logic              br, eq, taken, h2, h1;
    logic              stall_cyc, resolve;

    branch_operand_mux #(.DATA_W(DATA_W)) u_mux_rs (
        .sel        (forward_a),
        .reg_data   (id_rs_data),
        .exmem_data (exmem_alu_result),
        .memwb_data (memwb_write_data),
        .operand    (op_a)
    );

    branch_operand_mux #(.DATA_W(DATA_W)) u_mux_rt (
        .sel        (forward_b),
        .reg_data   (id_rt_data),
        .exmem_data (exmem_alu_result),
        .memwb_data (memwb_write_data),
        .operand    (op_b)
    );

    assign br    = id_beq | id_bne;
    assign eq    = (op_a == op_b);
    // beq wins when both decode bits are set
    assign taken = id_beq ? eq : (id_bne & ~eq);

    assign h2 = br & idex_reg_write & idex_mem_read & uses(idex_rd, id_rs, id_rt);
    assign h1 = br & ~h2 & ((idex_reg_write & uses(idex_rd, id_rs, id_rt)) |
                            (exmem_mem_read & uses(exmem_rd, id_rs, id_rt)));

    // remain counts stall cycles still owed after the current one
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        pc_src      = 1'b0;
        ifid_flush  = 1'b0;
        state_d     = state_q;
        remain_d    = remain_q;
        stall_cyc   = 1'b0;
        resolve     = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (h2 || h1) begin
                        stall_cyc = 1'b1;
                        remain_d  = h2 ? 2'd1 : 2'd0;
                        state_d   = h2 ? ST_STALL : ST_IDLE;
                    end else if (br) begin
                        resolve    = 1'b1;
                        pc_src     = taken;
                        ifid_flush = taken;
                    end else if (id_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
                ST_STALL: begin
                    stall_cyc = 1'b1;
                    if (remain_q <= 2'd1) begin
                        state_d  = ST_IDLE;
                        remain_d = 2'd0;
                    end else begin
                        remain_d = remain_q - 2'd1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    remain_d = 2'd0;
                end
            endcase
        end
        if (stall_cyc) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            remain_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (resolve && branch_cnt_q != CNT_MAX) begin
                branch_cnt_q <= branch_cnt_q + CNT_ONE;
            end
            if (resolve && taken && taken_cnt_q != CNT_MAX) begin
                taken_cnt_q <= taken_cnt_q + CNT_ONE;
            end
            if (stall_cyc && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: single-cycle vector table plus
// hand sequences for stalls, reset-in-stall and counter saturation.
module tb_branch_resolve_ctrl;

    localparam logic [4:0] O_IDLE  = 5'b11000;
    localparam logic [4:0] O_TAKEN = 5'b11011;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_JUMP  = 5'b11001;

    logic        clk, rst;
    logic        id_beq, id_bne, id_jump;
    logic [4:0]  id_rs, id_rt;
    logic [31:0] id_rs_data, id_rt_data;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] exmem_alu_result, memwb_write_data;
    logic        idex_reg_write, idex_mem_read;
    logic [4:0]  idex_rd;
    logic        exmem_mem_read;
    logic [4:0]  exmem_rd;
    logic        pc_write, ifid_write, idex_bubble, pc_src, ifid_flush;
    logic [15:0] branch_cnt, taken_cnt, stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_br, exp_tk, exp_st;

    branch_resolve_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .id_beq           (id_beq),
        .id_bne           (id_bne),
        .id_jump          (id_jump),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rs_data       (id_rs_data),
        .id_rt_data       (id_rt_data),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .exmem_alu_result (exmem_alu_result),
        .memwb_write_data (memwb_write_data),
        .idex_reg_write   (idex_reg_write),
        .idex_mem_read    (idex_mem_read),
        .idex_rd          (idex_rd),
        .exmem_mem_read   (exmem_mem_read),
        .exmem_rd         (exmem_rd),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .idex_bubble      (idex_bubble),
        .pc_src           (pc_src),
        .ifid_flush       (ifid_flush),
        .branch_cnt       (branch_cnt),
        .taken_cnt        (taken_cnt),
        .stall_cnt        (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        beq, bne, jump;
        logic [4:0]  rs, rt;
        logic [31:0] rs_data, rt_data;
        logic [1:0]  fa, fb;
        logic [31:0] exmem, memwb;
        logic        idex_rw, idex_mr;
        logic [4:0]  idex_rd;
        logic        exmem_mr;
        logic [4:0]  exmem_rd;
        logic [4:0]  exp_out;
        int          br_inc, tk_inc, st_inc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {pc_write, ifid_write, idex_bubble, pc_src, ifid_flush};
    endfunction

    task automatic clear_inputs();
        id_beq = 0; id_bne = 0; id_jump = 0; id_rs = 0; id_rt = 0;
        id_rs_data = 0; id_rt_data = 0; forward_a = 0; forward_b = 0;
        exmem_alu_result = 0; memwb_write_data = 0; idex_reg_write = 0;
        idex_mem_read = 0; idex_rd = 0; exmem_mem_read = 0; exmem_rd = 0;
    endtask

    task automatic apply(input vec_t v);
        id_beq = v.beq; id_bne = v.bne; id_jump = v.jump; id_rs = v.rs; id_rt = v.rt;
        id_rs_data = v.rs_data; id_rt_data = v.rt_data; forward_a = v.fa;
        forward_b = v.fb; exmem_alu_result = v.exmem; memwb_write_data = v.memwb;
        idex_reg_write = v.idex_rw; idex_mem_read = v.idex_mr; idex_rd = v.idex_rd;
        exmem_mem_read = v.exmem_mr; exmem_rd = v.exmem_rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
        exp_br = 0; exp_tk = 0; exp_st = 0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(exp_br));
        check({tag, ".taken_cnt"},  32'(taken_cnt),  32'(exp_tk));
        check({tag, ".stall_cnt"},  32'(stall_cnt),  32'(exp_st));
    endtask

    initial begin
        //          beq bne j  rs rt rs_data        rt_data        fa     fb     exmem          memwb    rw mr rd  emr erd exp      br tk st
        vecs[0]  = '{1, 0, 0, 1, 2, 32'h5,         32'h5,         2'b00, 2'b00, 32'h0,         32'h0,   0, 0, 0,  0, 0,  O_TAKEN, 1, 1, 0};
        vecs[1]  = '{0, 1, 0, 3, 4, 32'h99,        32'h7,         2'b10, 2'b00, 32'h7,         32'h0,   0, 0, 0,  0, 0,  O_IDLE,  1, 0, 0};
        vecs[2]  = '{0, 1, 0, 3, 4, 32'h1,         32'h2,         2'b00, 2'b00, 32'h0,         32'h0,   0, 0, 0,  0, 0,  O_TAKEN, 1, 1, 0};
        vecs[3]  = '{1, 0, 0, 5, 6, 32'h0,         32'hAB,        2'b01, 2'b11, 32'h0,         32'hAB,  0, 0, 0,  0, 0,  O_TAKEN, 1, 1, 0};
        vecs[4]  = '{1, 0, 0, 5, 6, 32'h1,         32'h1,         2'b11, 2'b10, 32'h8000_0001, 32'h0,   0, 0, 0,  0, 0,  O_IDLE,  1, 0, 0};
        vecs[5]  = '{1, 1, 0, 1, 2, 32'h10,        32'h10,        2'b00, 2'b00, 32'h0,         32'h0,   0, 0, 0,  0, 0,  O_TAKEN, 1, 1, 0};
        vecs[6]  = '{0, 0, 1, 1, 2, 32'h1,         32'h2,         2'b00, 2'b00, 32'h0,         32'h0,   0, 0, 0,  0, 0,  O_JUMP,  0, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 2, 32'h1,         32'h2,         2'b00, 2'b00, 32'h0,         32'h0,   1, 1, 1,  0, 0,  O_IDLE,  0, 0, 0};
        vecs[8]  = '{1, 0, 0, 0, 5, 32'h0,         32'h0,         2'b00, 2'b00, 32'h0,         32'h0,   1, 1, 0,  0, 0,  O_TAKEN, 1, 1, 0};
        vecs[9]  = '{1, 0, 0, 4, 6, 32'h1,         32'h2,         2'b00, 2'b00, 32'h0,         32'h0,   0, 0, 0,  1, 6,  O_STALL, 0, 0, 1};
        vecs[10] = '{0, 1, 0, 3, 4, 32'h3,         32'h3,         2'b00, 2'b00, 32'h0,         32'h0,   1, 0, 7,  0, 0,  O_IDLE,  1, 0, 0};
        vecs[11] = '{0, 1, 0, 9, 10, 32'h5,        32'h6,         2'b01, 2'b00, 32'h0,         32'h6,   0, 0, 0,  0, 0,  O_IDLE,  1, 0, 0};

        // Reset state
        clear_inputs();
        rst = 1'b1;
        #3;
        check("reset.outs", 32'(outs()), 32'(O_IDLE));
        exp_br = 0; exp_tk = 0; exp_st = 0;
        check_cnts("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single-cycle vectors
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i]);
            @(negedge clk);
            check($sformatf("vec%0d.outs", i), 32'(outs()), 32'(vecs[i].exp_out));
            step();
            exp_br += vecs[i].br_inc;
            exp_tk += vecs[i].tk_inc;
            exp_st += vecs[i].st_inc;
            check_cnts($sformatf("vec%0d", i));
        end

        // H2: lw in ID/EX feeding beq rs -> two stall cycles then resolve
        do_reset();
        id_beq = 1; id_rs = 8; id_rt = 2; id_rs_data = 32'h1; id_rt_data = 32'h42;
        idex_reg_write = 1; idex_mem_read = 1; idex_rd = 8;
        @(negedge clk);
        check("h2.c0.outs", 32'(outs()), 32'(O_STALL));
        step();
        idex_reg_write = 0; idex_mem_read = 0; idex_rd = 0;
        exmem_mem_read = 1; exmem_rd = 8;
        @(negedge clk);
        check("h2.c1.outs", 32'(outs()), 32'(O_STALL));
        step();
        exmem_mem_read = 0; exmem_rd = 0;
        forward_a = 2'b01; memwb_write_data = 32'h42;
        @(negedge clk);
        check("h2.c2.outs", 32'(outs()), 32'(O_TAKEN));
        step();
        exp_br = 1; exp_tk = 1; exp_st = 2;
        check_cnts("h2");

        // H1: add in ID/EX feeding beq rt -> one stall then forward from EX/MEM
        do_reset();
        id_beq = 1; id_rs = 3; id_rt = 9; id_rs_data = 32'h11; id_rt_data = 32'h0;
        idex_reg_write = 1; idex_rd = 9;
        @(negedge clk);
        check("h1.c0.outs", 32'(outs()), 32'(O_STALL));
        step();
        idex_reg_write = 0; idex_rd = 0;
        forward_b = 2'b10; exmem_alu_result = 32'h11;
        @(negedge clk);
        check("h1.c1.outs", 32'(outs()), 32'(O_TAKEN));
        step();
        exp_br = 1; exp_tk = 1; exp_st = 1;
        check_cnts("h1");

        // Reset asserted during the first STALL cycle of an H2 hazard
        do_reset();
        id_beq = 1; id_rs = 8; idex_reg_write = 1; idex_mem_read = 1; idex_rd = 8;
        step();
        check("rststall.pre.outs", 32'(outs()), 32'(O_STALL));
        check("rststall.pre.stall_cnt", 32'(stall_cnt), 32'd1);
        rst = 1'b1;
        #1;
        check("rststall.outs", 32'(outs()), 32'(O_IDLE));
        exp_br = 0; exp_tk = 0; exp_st = 0;
        check_cnts("rststall");
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        id_beq = 1; id_rs = 1; id_rt = 2; id_rs_data = 32'h3; id_rt_data = 32'h3;
        #1;
        check("rststall.idle.outs", 32'(outs()), 32'(O_TAKEN));
        step();
        exp_br = 1; exp_tk = 1;
        check_cnts("rststall.idle");

        // Saturate stall_cnt with back-to-back H1 stalls
        do_reset();
        id_bne = 1; id_rs = 4; idex_reg_write = 1; idex_rd = 4;
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        check("sat.stall_cnt", 32'(stall_cnt), 32'hFFFF);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check("sat.hold.stall_cnt", 32'(stall_cnt), 32'hFFFF);
        check("sat.outs", 32'(outs()), 32'(O_STALL));
        clear_inputs();
        id_jump = 1;
        @(negedge clk);
        check("jump.outs", 32'(outs()), 32'(O_JUMP));
        step();
        check("jump.stall_cnt", 32'(stall_cnt), 32'hFFFF);
        check("jump.branch_cnt", 32'(branch_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
